// File: rtl/adc_scan_sequencer.sv
// Free-running channel scanner for an ADC128S022-style serial ADC (16-SCLK frames).
// Averages 2^AVG_LOG2 samples per channel and publishes them through a strobe and a register file.
module adc_scan_sequencer #(
    parameter int         CLK_HALF = 8,
    parameter logic [7:0] CH_MASK  = 8'hFF,
    parameter int         AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_saddr,
    input  logic        adc_sdat,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        busy
);
    localparam int CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
    localparam int AW = 12 + AVG_LOG2;
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NW-1:0] N_LAST = NW'((1 << AVG_LOG2) - 1);

    function automatic logic [2:0] lowest_ch();
        logic [2:0] c;
        c = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (CH_MASK[i]) c = 3'(i);
        end
        return c;
    endfunction

    localparam logic [2:0] FIRST_CH = lowest_ch();

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_k;
    logic            phase_hi;
    logic [11:0]     shift_reg;
    logic [2:0]      cur_ch, prev_ch, next_ch;
    logic            prime;
    logic [AW-1:0]   acc [8];
    logic [NW-1:0]   navg [8];
    logic [11:0]     result [8];
    logic [AW-1:0]   acc_sum;
    logic [11:0]     avg_val;
    logic            half_done, frame_end;

    assign half_done = (cnt == HALF_LAST);
    assign frame_end = (state == CS_HOLD) && half_done;
    assign acc_sum   = acc[prev_ch] + AW'(shift_reg);
    assign avg_val   = acc_sum[AW-1:AVG_LOG2];

    always_comb begin
        state_nxt = state;
        adc_cs_n  = 1'b1;
        adc_sclk  = 1'b1;
        adc_saddr = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable && (CH_MASK != 8'h00)) state_nxt = CS_SETUP;
            end
            CS_SETUP: begin
                adc_cs_n = 1'b0;
                if (half_done) state_nxt = SHIFT;
            end
            SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = phase_hi;
                // bit_k only advances at the start of a low phase, so DIN follows it directly
                case (bit_k)
                    4'd2:    adc_saddr = cur_ch[2];
                    4'd3:    adc_saddr = cur_ch[1];
                    4'd4:    adc_saddr = cur_ch[0];
                    default: adc_saddr = 1'b0;
                endcase
                if (half_done && phase_hi && (bit_k == 4'd15)) state_nxt = CS_HOLD;
            end
            CS_HOLD: begin
                if (half_done) state_nxt = enable ? CS_SETUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        next_ch = cur_ch;
        for (int i = 7; i >= 1; i--) begin
            if (CH_MASK[cur_ch + 3'(i)]) next_ch = cur_ch + 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_k     <= '0;
            phase_hi  <= 1'b0;
            shift_reg <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) || half_done) cnt <= '0;
            else                              cnt <= cnt + 1'b1;
            if (state == IDLE) begin
                bit_k    <= '0;
                phase_hi <= 1'b0;
            end else if ((state == SHIFT) && half_done) begin
                phase_hi <= ~phase_hi;
                // the four leading zero bits fall off the top; bit_k wraps to 0 after bit 15
                if (phase_hi) bit_k <= bit_k + 4'd1;
                else          shift_reg <= {shift_reg[10:0], adc_sdat};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_ch       <= FIRST_CH;
            prev_ch      <= 3'd0;
            prime        <= 1'b1;
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
            sample_data  <= 12'd0;
            rd_data      <= 12'd0;
            for (int i = 0; i < 8; i++) begin
                acc[i]    <= '0;
                navg[i]   <= '0;
                result[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            rd_data      <= result[rd_addr];
            if (state == IDLE) begin
                prime  <= 1'b1;
                cur_ch <= FIRST_CH;
            end
            if (frame_end) begin
                prev_ch <= cur_ch;
                cur_ch  <= next_ch;
                prime   <= 1'b0;
                // frame data is the conversion addressed one frame earlier
                if (!prime) begin
                    if (navg[prev_ch] == N_LAST) begin
                        result[prev_ch] <= avg_val;
                        acc[prev_ch]    <= '0;
                        navg[prev_ch]   <= '0;
                        sample_valid    <= 1'b1;
                        sample_ch       <= prev_ch;
                        sample_data     <= avg_val;
                    end else begin
                        acc[prev_ch]  <= acc_sum;
                        navg[prev_ch] <= navg[prev_ch] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: four configurations, each with a behavioural ADC model,
// and a scoreboard of expected {instance, channel, data} strobes.
module tb_adc_scan_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [3:0]  en = 4'h0;
    logic [3:0]  cs_n, sclk, saddr, sv, bsy;
    logic [2:0]  rda [4] = '{default: 3'd0};
    logic [11:0] rdd [4];
    logic [2:0]  sch [4];
    logic [11:0] sdt [4];
    logic [11:0] mval [4][8];
    logic [11:0] seq2 [$];
    logic [2:0]  alog0 [$];
    logic [2:0]  alog3 [$];
    logic [16:0] exp_q [$];
    int          n_chk = 0, n_pass = 0;
    int          nstb [4] = '{default: 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int         CH  = (g == 0) ? 8 : 2;
        localparam logic [7:0] MSK = (g == 0) ? 8'h03 : (g == 1) ? 8'h08 : (g == 2) ? 8'h20 : 8'h81;
        localparam int         AVG = (g == 2) ? 2 : 0;
        logic        sd = 1'b0;
        int          k = 0;
        logic [2:0]  a = 3'd0, pa = 3'd0;
        logic [15:0] w = 16'd0;

        adc_scan_sequencer #(.CLK_HALF(CH), .CH_MASK(MSK), .AVG_LOG2(AVG)) dut (
            .clk(clk), .reset(rst), .enable(en[g]),
            .adc_cs_n(cs_n[g]), .adc_sclk(sclk[g]), .adc_saddr(saddr[g]), .adc_sdat(sd),
            .rd_addr(rda[g]), .rd_data(rdd[g]),
            .sample_valid(sv[g]), .sample_ch(sch[g]), .sample_data(sdt[g]), .busy(bsy[g])
        );

        // ADC returns the conversion addressed in the previous complete frame
        always @(negedge cs_n[g]) begin
            k = 0;
            if (g == 2 && seq2.size() > 0) w = {4'h0, seq2.pop_front()};
            else                           w = {4'h0, mval[g][pa]};
        end
        always @(negedge sclk[g]) if (cs_n[g] === 1'b0 && k < 16) begin
            sd = w[4'(15 - k)];
            k++;
        end
        always @(posedge sclk[g]) if (cs_n[g] === 1'b0 && k >= 3 && k <= 5) a = {a[1:0], saddr[g]};
        always @(posedge cs_n[g]) if (k == 16) begin
            pa = a;
            if (g == 0) alog0.push_back(a);
            if (g == 3) alog3.push_back(a);
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (sv[g] === 1'b1) begin
                logic [16:0] e;
                nstb[g]++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
                chk("strobe", {15'd0, 2'(g), sch[g], sdt[g]}, {15'd0, e});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int g, input logic [2:0] ch, input logic [11:0] d);
        exp_q.push_back({2'(g), ch, d});
    endtask

    task automatic wait_cs(input int g, input logic lvl, input int budget);
        int t = 0;
        while (cs_n[g] !== lvl && t < budget) begin @(negedge clk); t++; end
        if (t >= budget) chk("cs_wait_timeout", {31'd0, cs_n[g]}, {31'd0, lvl});
    endtask

    task automatic wait_falls(input int g, input int n, input int budget);
        int t = 0, f = 0;
        logic p;
        p = sclk[g];
        while (f < n && t < budget) begin
            @(negedge clk); t++;
            if (p === 1'b1 && sclk[g] === 1'b0) f++;
            p = sclk[g];
        end
        if (f < n) chk("sclk_fall_timeout", f, n);
    endtask

    task automatic wait_idle(input int g, input int budget);
        int t = 0;
        while (bsy[g] !== 1'b0 && t < budget) begin @(negedge clk); t++; end
        if (t >= budget) chk("idle_timeout", {31'd0, bsy[g]}, 0);
    endtask

    task automatic wait_q(input int budget);
        int t = 0;
        while (exp_q.size() > 0 && t < budget) begin @(negedge clk); t++; end
        if (t >= budget) chk("strobe_timeout", exp_q.size(), 0);
    endtask

    task automatic meas_frame(output int lo_cyc, output int pulses, output int bad, output int setup);
        int sl = 0;
        lo_cyc = 0; pulses = 0; bad = 0; setup = 0;
        while (cs_n[0] === 1'b0 && lo_cyc < 2000) begin
            lo_cyc++;
            if (sclk[0] === 1'b0) sl++;
            else if (sl > 0) begin
                pulses++;
                if (sl != 8) bad++;
                sl = 0;
            end else if (pulses == 0) setup++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lo, np, bad, setup, hi, s0;
        for (int g = 0; g < 4; g++) for (int c = 0; c < 8; c++) mval[g][c] = 12'h000;

        // reset held with enable high
        en = 4'hF;
        cyc(3);
        for (int g = 0; g < 4; g++) begin
            chk("rst_cs_n", {31'd0, cs_n[g]}, 1);
            chk("rst_sclk", {31'd0, sclk[g]}, 1);
            chk("rst_busy", {31'd0, bsy[g]}, 0);
            chk("rst_valid", {31'd0, sv[g]}, 0);
            chk("rst_sample", {17'd0, sch[g], sdt[g]}, 0);
        end
        en = 4'h0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rda[0] = 3'(i);
            cyc(1);
            chk("rst_rd_data", {20'd0, rdd[0]}, 0);
        end

        // frame shape, CLK_HALF=8, mask 0x03
        mval[0][0] = 12'h123; mval[0][1] = 12'h456;
        push_exp(0, 3'd0, 12'h123);
        push_exp(0, 3'd1, 12'h456);
        en[0] = 1'b1;
        cyc(1);
        chk("start_cs_n", {31'd0, cs_n[0]}, 0);
        chk("start_busy", {31'd0, bsy[0]}, 1);
        for (int f = 0; f < 2; f++) begin
            meas_frame(lo, np, bad, setup);
            chk("cs_low_cycles", lo, 264);
            chk("sclk_pulses", np, 16);
            chk("sclk_bad_pulses", bad, 0);
            chk("cs_to_sclk_fall", setup, 8);
            hi = 0;
            while (cs_n[0] === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
            chk("cs_high_cycles", hi, 8);
        end
        wait_q(600);
        push_exp(0, 3'd0, 12'h123);
        en[0] = 1'b0;
        wait_idle(0, 600);
        wait_q(20);
        chk("addr_log0_len", alog0.size(), 4);
        for (int i = 0; i < 4 && i < alog0.size(); i++) chk("addr_seq0", {29'd0, alog0[i]}, i % 2);

        // single-channel capture, mask 0x08
        mval[1][3] = 12'hABC;
        en[1] = 1'b1;
        wait_cs(1, 1'b0, 20);
        wait_cs(1, 1'b1, 200);
        cyc(4);
        chk("prime_no_strobe", nstb[1], 0);
        push_exp(1, 3'd3, 12'hABC);
        wait_q(200);
        rda[1] = 3'd3;
        cyc(1);
        chk("rd_data_ch3", {20'd0, rdd[1]}, 12'hABC);

        // enable dropped at bit 8: frame completes and publishes
        wait_falls(1, 9, 200);
        en[1] = 1'b0;
        push_exp(1, 3'd3, 12'hABC);
        s0 = 0;
        while (bsy[1] === 1'b1 && s0 < 200) begin @(negedge clk); s0++; end
        chk("strobe_at_busy_fall", {31'd0, sv[1]}, 1);
        wait_q(20);

        // reset at bit 8: abort, then prime again
        en[1] = 1'b1;
        wait_falls(1, 9, 200);
        rst = 1'b1;
        cyc(1);
        chk("reset_abort_cs_n", {31'd0, cs_n[1]}, 1);
        chk("reset_abort_busy", {31'd0, bsy[1]}, 0);
        rst = 1'b0;
        cyc(1);
        chk("rd_after_reset", {20'd0, rdd[1]}, 0);
        s0 = nstb[1];
        wait_cs(1, 1'b0, 20);
        wait_cs(1, 1'b1, 200);
        cyc(4);
        chk("reprime_no_strobe", nstb[1], s0);
        push_exp(1, 3'd3, 12'hABC);
        wait_q(200);
        push_exp(1, 3'd3, 12'hABC);
        en[1] = 1'b0;
        wait_idle(1, 200);
        wait_q(20);

        // averaging, 4 samples on channel 5
        seq2.push_back(12'd999);
        seq2.push_back(12'd100); seq2.push_back(12'd101);
        seq2.push_back(12'd102); seq2.push_back(12'd104);
        push_exp(2, 3'd5, 12'd101);
        en[2] = 1'b1;
        wait_q(800);
        en[2] = 1'b0;
        wait_idle(2, 200);
        cyc(3);
        chk("avg_one_strobe", nstb[2], 1);
        rda[2] = 3'd5;
        cyc(2);
        chk("avg_rd_data", {20'd0, rdd[2]}, 12'd101);
        // the frame that completed after enable fell left one zero sample pending
        seq2.push_back(12'd999);
        seq2.push_back(12'd200); seq2.push_back(12'd200); seq2.push_back(12'd200);
        push_exp(2, 3'd5, 12'd150);
        en[2] = 1'b1;
        wait_q(800);
        en[2] = 1'b0;
        wait_idle(2, 200);
        cyc(3);
        chk("avg_second_strobe", nstb[2], 2);

        // wrap 7->0 and attribution, mask 0x81
        mval[3][0] = 12'h111; mval[3][7] = 12'h777;
        push_exp(3, 3'd0, 12'h111);
        push_exp(3, 3'd7, 12'h777);
        en[3] = 1'b1;
        wait_q(400);
        push_exp(3, 3'd0, 12'h111);
        en[3] = 1'b0;
        wait_idle(3, 200);
        wait_q(20);
        chk("addr_log3_len", alog3.size(), 4);
        for (int i = 0; i < 4 && i < alog3.size(); i++) chk("addr_seq3", {29'd0, alog3[i]}, (i % 2) ? 7 : 0);
        rda[3] = 3'd0;
        cyc(2);
        chk("wrap_rd_ch0", {20'd0, rdd[3]}, 12'h111);
        rda[3] = 3'd7;
        cyc(2);
        chk("wrap_rd_ch7", {20'd0, rdd[3]}, 12'h777);

        cyc(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
